// File: rtl/request_buffer_pkg.sv
// Shared types and sizing for the request buffer slice.
// Package mc_pkg is imported by the interface, table and top.
package mc_pkg;
    localparam int DEPTH     = 16;
    localparam int IDX_W     = 4;
    localparam int AGE_W     = 6;
    localparam int BANK_W    = 3;
    localparam int NBANK     = 1 << BANK_W;
    localparam int ROW_W     = 14;
    localparam int COL_W     = 10;
    localparam int ID_W      = 4;
    localparam int AGE_SHIFT = 3;

    localparam int FLAG_ROW_HIT   = 2;
    localparam int FLAG_READ      = 1;
    localparam int FLAG_BANK_IDLE = 0;

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic              write;
        logic [ID_W-1:0]   id;
    } req_entry_t;
endpackage

// File: rtl/request_buffer_if.sv
// Request/grant/issue bundle between the buffer and its neighbours.
// The master side is the environment; the buffer itself is the slave.
interface request_buffer_if;
    import mc_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [BANK_W-1:0]      req_bank;
    logic [ROW_W-1:0]       req_row;
    logic [COL_W-1:0]       req_col;
    logic                   req_write;
    logic [ID_W-1:0]        req_id;
    logic [NBANK-1:0]       bank_busy;
    logic                   pre_valid;
    logic [BANK_W-1:0]      pre_bank;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH*AGE_W-1:0] entry_age;
    logic [DEPTH*3-1:0]     entry_flags;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic                   issue_valid;
    logic [BANK_W-1:0]      issue_bank;
    logic [ROW_W-1:0]       issue_row;
    logic [COL_W-1:0]       issue_col;
    logic                   issue_write;
    logic [ID_W-1:0]        issue_id;
    logic                   grant_err;

    modport master (
        output req_valid, req_bank, req_row, req_col, req_write, req_id,
        output bank_busy, pre_valid, pre_bank, grant_valid, grant_idx,
        input  req_ready, entry_valid, entry_age, entry_flags,
        input  issue_valid, issue_bank, issue_row, issue_col,
        input  issue_write, issue_id, grant_err
    );

    modport slave (
        input  req_valid, req_bank, req_row, req_col, req_write, req_id,
        input  bank_busy, pre_valid, pre_bank, grant_valid, grant_idx,
        output req_ready, entry_valid, entry_age, entry_flags,
        output issue_valid, issue_bank, issue_row, issue_col,
        output issue_write, issue_id, grant_err
    );
endinterface

// File: rtl/request_buffer_open_row.sv
// Per-bank open-row tracker: opened by an issue, closed by precharge.
module open_row_table
    import mc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_i,
    input  logic [BANK_W-1:0]           set_bank_i,
    input  logic [ROW_W-1:0]            set_row_i,
    input  logic                        clr_i,
    input  logic [BANK_W-1:0]           clr_bank_i,
    output logic [NBANK-1:0]            row_open_o,
    output logic [NBANK-1:0][ROW_W-1:0] open_row_o
);
    logic [NBANK-1:0]            open_q, open_d;
    logic [NBANK-1:0][ROW_W-1:0] row_q, row_d;

    // Set is applied after clear so an issue beats a same-bank precharge.
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (clr_i) open_d[clr_bank_i] = 1'b0;
        if (set_i) begin
            open_d[set_bank_i] = 1'b1;
            row_d[set_bank_i]  = set_row_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= '0;
            row_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
        end
    end

    assign row_open_o = open_q;
    assign open_row_o = row_q;
endmodule

// File: rtl/request_buffer.sv
// 16-entry aging request queue feeding the priority scorer.
// Define AGE_PRESCALE_EN to age only once per 2^AGE_SHIFT cycles.
module request_buffer
    import mc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    request_buffer_if.slave bus
);
    req_entry_t                  slot_q [DEPTH];
    logic [AGE_W-1:0]            age_q  [DEPTH];
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [IDX_W-1:0]            alloc_idx;
    logic                        alloc, grant_ok, age_tick;
    req_entry_t                  new_ent, gnt_ent, iss_q;
    logic                        iss_valid_q, gerr_q;
    logic [NBANK-1:0]            row_open;
    logic [NBANK-1:0][ROW_W-1:0] open_row;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end

    assign bus.req_ready = ~&valid_q;
    assign alloc    = bus.req_valid && bus.req_ready;
    assign new_ent  = '{bus.req_bank, bus.req_row, bus.req_col,
                        bus.req_write, bus.req_id};
    assign gnt_ent  = slot_q[bus.grant_idx];
    assign grant_ok = bus.grant_valid && valid_q[bus.grant_idx];

`ifdef AGE_PRESCALE_EN
    logic [AGE_SHIFT-1:0] pre_q;

    always_ff @(posedge clk) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_q + 1'b1;
    end

    assign age_tick = &pre_q;
`else
    assign age_tick = 1'b1;
`endif

    always_comb begin
        valid_d = valid_q;
        if (grant_ok) valid_d[bus.grant_idx] = 1'b0;
        if (alloc)    valid_d[alloc_idx]     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            iss_valid_q <= 1'b0;
            gerr_q      <= 1'b0;
            iss_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            iss_valid_q <= grant_ok;
            gerr_q      <= bus.grant_valid && !valid_q[bus.grant_idx];
            if (grant_ok) iss_q <= gnt_ent;
            for (int i = 0; i < DEPTH; i++)
                if (valid_q[i] && age_tick && age_q[i] != AGE_MAX)
                    age_q[i] <= age_q[i] + 1'b1;
            if (grant_ok) age_q[bus.grant_idx] <= '0;
            if (alloc) begin
                slot_q[alloc_idx] <= new_ent;
                age_q[alloc_idx]  <= '0;
            end
        end
    end

    open_row_table u_ort (
        .clk        (clk),
        .rst        (rst),
        .set_i      (grant_ok),
        .set_bank_i (gnt_ent.bank),
        .set_row_i  (gnt_ent.row),
        .clr_i      (bus.pre_valid),
        .clr_bank_i (bus.pre_bank),
        .row_open_o (row_open),
        .open_row_o (open_row)
    );

    always_comb begin
        bus.entry_age   = '0;
        bus.entry_flags = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                bus.entry_age[i*AGE_W +: AGE_W] = age_q[i];
                bus.entry_flags[i*3 + FLAG_ROW_HIT] =
                    row_open[slot_q[i].bank] &&
                    (open_row[slot_q[i].bank] == slot_q[i].row);
                bus.entry_flags[i*3 + FLAG_READ] = ~slot_q[i].write;
                bus.entry_flags[i*3 + FLAG_BANK_IDLE] =
                    ~bus.bank_busy[slot_q[i].bank];
            end
        end
    end

    assign bus.entry_valid = valid_q;
    assign bus.issue_valid = iss_valid_q;
    assign bus.issue_bank  = iss_q.bank;
    assign bus.issue_row   = iss_q.row;
    assign bus.issue_col   = iss_q.col;
    assign bus.issue_write = iss_q.write;
    assign bus.issue_id    = iss_q.id;
    assign bus.grant_err   = gerr_q;
endmodule
